// File: rtl/alu_defs.sv
// alu_defs: opcodes, legality check and controller state encoding for alu_share_ctrl
package alu_defs;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, one-hot grant, ptr names the favoured port on a tie
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] | ptr);
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters with round-robin grant and fixed settle time
module alu_share_ctrl
  import alu_defs::*;
#(
  parameter int n      = 64,
  parameter int SETTLE = 2
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         ReqValid0,
  input  logic         ReqValid1,
  output logic         ReqReady0,
  output logic         ReqReady1,
  input  logic [n-1:0] ReqA0,
  input  logic [n-1:0] ReqA1,
  input  logic [n-1:0] ReqB0,
  input  logic [n-1:0] ReqB1,
  input  logic [3:0]   ReqCtrl0,
  input  logic [3:0]   ReqCtrl1,
  output logic         RespValid0,
  output logic         RespValid1,
  output logic [n-1:0] RespW,
  output logic         RespZero,
  output logic         RespErr,
  output logic [n-1:0] AluA,
  output logic [n-1:0] AluB,
  output logic [3:0]   AluCtrl,
  input  logic [n-1:0] AluW,
  input  logic         AluZero
);
  logic [1:0]   state;
  logic [3:0]   cnt;
  logic         ptr;
  logic         owner;
  logic         err;
  logic [1:0]   gnt;
  logic         idle;
  logic         win;
  logic [n-1:0] sel_a;
  logic [n-1:0] sel_b;
  logic [3:0]   sel_c;
  rr_arb2 u_arb (.req({ReqValid1, ReqValid0}), .ptr(ptr), .gnt(gnt));
  assign idle       = (state == S_IDLE) && !Reset;
  assign ReqReady0  = idle & gnt[0];
  assign ReqReady1  = idle & gnt[1];
  assign RespValid0 = (state == S_DONE) && !owner && !Reset;
  assign RespValid1 = (state == S_DONE) && owner && !Reset;
  assign win        = gnt[1];
  assign sel_a      = win ? ReqA1 : ReqA0;
  assign sel_b      = win ? ReqB1 : ReqB0;
  assign sel_c      = win ? ReqCtrl1 : ReqCtrl0;
  // accept in IDLE, count down the settle time in BUSY, pulse the owner in DONE
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      err      <= 1'b0;
      AluA     <= '0;
      AluB     <= '0;
      AluCtrl  <= '0;
      RespW    <= '0;
      RespZero <= 1'b0;
      RespErr  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (|gnt) begin
        owner <= win;
        ptr   <= ~win;
        cnt   <= 4'(SETTLE);
        err   <= !is_legal(sel_c);
        state <= S_BUSY;
        if (is_legal(sel_c)) begin
          AluA    <= sel_a;
          AluB    <= sel_b;
          AluCtrl <= sel_c;
        end
      end
    end else if (state == S_BUSY) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        RespW    <= err ? '0 : AluW;
        RespZero <= err | AluZero;
        RespErr  <= err;
        state    <= S_DONE;
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencing controller that lets two requesters share one ALU instance.
  - Port 0: main datapath.
  - Port 1: auxiliary unit, e.g. address/branch helper.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the winner's operands and opcode onto the ALU inputs and waits a fixed settle time.
- Captures the ALU result and Zero flag, then returns them as a one-cycle response pulse to the owner.
- Sits between the requesters and the existing 64-bit ALU (BusA/BusB/ALUCtrl → BusW/Zero).

Parameters:
- n, 64, operand/result width.
- SETTLE, 2, clock cycles the ALU needs for BusW/Zero to settle after its inputs change; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid0, ReqValid1  input  1 each  request present.
- ReqReady0, ReqReady1  output  1 each  request accepted this edge when Valid&&Ready.
- ReqA0, ReqA1  input  n each  operand A.
- ReqB0, ReqB1  input  n each  operand B.
- ReqCtrl0, ReqCtrl1  input  4 each  ALU opcode.
- RespValid0, RespValid1  output  1 each  one-cycle result pulse.
- RespW  output  n  shared result bus, qualified by RespValid0/1.
- RespZero  output  1  shared Zero flag, qualified by RespValid0/1.
- RespErr  output  1  illegal opcode flag, qualified by RespValid0/1.
- AluA  output  n  drives ALU BusA.
- AluB  output  n  drives ALU BusB.
- AluCtrl  output  4  drives ALU ALUCtrl.
- AluW  input  n  from ALU BusW.
- AluZero  input  1  from ALU Zero.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (Reset). Reset wins over every other event.
- Reset values:
  - state=IDLE, priority pointer=0, settle counter=0, owner=0.
  - AluA=0, AluB=0, AluCtrl=4'b0000.
  - RespW=0, RespZero=0, RespErr=0, RespValid0/1=0.
  - ReqReady0/1=0 while Reset is high.
- States: IDLE → BUSY → DONE → IDLE.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the port named by the pointer.
  - ReqReady of the granted port is 1; the other port's ReqReady is 0. No ReqReady is asserted in BUSY or DONE.
  - Ready depends combinationally on Valid. Requesters must not make Valid depend on Ready.
- Accept edge (Valid&&Ready in IDLE):
  - Register ReqA/ReqB/ReqCtrl of the winner into AluA/AluB/AluCtrl.
  - Record owner.
  - Load settle counter with SETTLE.
  - Set pointer to the other port.
  - Go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter is 1: RespW←AluW, RespZero←AluZero, RespErr←0. Go to DONE.
  - AluA/AluB/AluCtrl stay constant throughout BUSY.
- DONE:
  - RespValid of the owner is 1 for exactly this one cycle. The other port's RespValid is 0.
  - Next edge → IDLE.
  - RespW/RespZero/RespErr hold their values until the next capture.
- Latency: accept edge k → RespValid high in the cycle after edge k+SETTLE.
- Minimum spacing between accept edges is SETTLE+2 cycles.
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 LSL, 0100 LSR, 0110 SUB, 0111 PassB.
- Illegal opcode (any other code):
  - Request is accepted normally.
  - AluA/AluB/AluCtrl keep their previous values.
  - Timing is identical to a legal request.
  - Response is RespW=0, RespZero=1, RespErr=1; AluW/AluZero are ignored.
- Responses have no backpressure. A requester must sample RespW in the RespValid cycle.
- Valid dropped before acceptance: nothing is recorded, and grant is re-evaluated every IDLE cycle.
- Reset mid-operation (BUSY or DONE): the in-flight request is discarded. No RespValid is issued, including a pending DONE pulse.
- Counter width is 4 bits. SETTLE=1 means capture on the first edge after accept.

Decomposition:
- Shared package alu_defs:
  - opcode constants AND/OR/ADD/LSL/LSR/SUB/PassB;
  - an is-legal-opcode function;
  - state encoding IDLE/BUSY/DONE.
- The ALU itself is not reused here; this block only drives its inputs.
- One sub-module: rr_arb2.
  - Inputs: two requests, pointer.
  - Outputs: one-hot grant.
  - Purely combinational; the pointer register lives in alu_share_ctrl.

Test Plan:
1. Single op, SETTLE=2: port0 sends A=5, B=3, ADD; ALU model returns 8 after 2 cycles → ReqReady0 at accept; RespValid0 exactly 1 cycle, 3 cycles after accept edge; RespW=8, RespZero=0, RespErr=0; RespValid1 stays 0.
2. Contention: both valid in the same IDLE cycle after reset.
   - Port0 (SUB 7-7) wins first → RespW=0, RespZero=1.
   - Port1 (OR 0xF0|0x0F) is served next → RespW=0xFF.
   - A third simultaneous pair goes to port0 again.
3. Illegal opcode 4'b1010 from port1 → AluCtrl unchanged; RespValid1 with RespW=0, RespZero=1, RespErr=1.
4. Reset asserted in the cycle after accept → no RespValid on either port; all outputs 0; pointer 0. A following request on port1 is served normally.
5. Back-to-back on port0 with Valid held high → accept edges spaced exactly SETTLE+2=4 cycles apart; ReqReady0 low in BUSY/DONE. SETTLE=1 variant: spacing 3, latency 2.
